// File: rtl/fifo_drain_sched_pkg.sv
// Shared types and helpers for the FIFO drain scheduler.
// Holds the FSM encoding, source index type and round-robin search.
package fifo_drain_sched_pkg;

  localparam int N_SRC_DEF = 24;
  localparam int SRC_MAX   = 31;

  // 1-based source index; 0 means "no source"
  typedef logic [4:0] src_idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_OUT
  } state_t;

  // First eligible index after last, wrapping n -> 1; 0 if none.
  // Scans offsets high to low so the nearest offset wins.
  function automatic src_idx_t rr_search(
    input logic [SRC_MAX:1] elig,
    input int               n,
    input src_idx_t         last
  );
    src_idx_t pick;
    src_idx_t idx;
    pick = '0;
    for (int off = SRC_MAX; off >= 1; off--) begin
      if (off <= n) begin
        idx = src_idx_t'((int'(last) - 1 + off) % n + 1);
        if (elig[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_drain_sched_rr_pick.sv
// Rotating-priority picker for the FIFO drain scheduler.
// Searches upward from last_grant+1, wrapping to source 1.
module rr_pick
  import fifo_drain_sched_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
) (
  input  logic [1:N_SRC] eligible,
  input  src_idx_t       last_grant,
  output logic           grant_valid,
  output src_idx_t       grant_idx
);

  logic [SRC_MAX:1] elig_w;

  // Widen the request vector to the search function's fixed width
  always_comb begin
    elig_w = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      elig_w[i] = eligible[i];
    end
  end

  assign grant_idx   = rr_search(elig_w, N_SRC, last_grant);
  assign grant_valid = (grant_idx != '0);

endmodule

// File: rtl/fifo_drain_sched.sv
// Drains serial block FIFOs one word at a time, round-robin.
// A single output buffer throttles grants until the word is taken.
module fifo_drain_sched
  import fifo_drain_sched_pkg::*;
#(
  parameter int N_SRC     = N_SRC_DEF,
  parameter int WORD_BITS = 64,
  parameter int READ_LAT  = 2
) (
  input  logic                 fifo_clk,
  input  logic                 fifo_rst_n,
  input  logic [1:N_SRC]       fifo_empty,
  output logic [1:N_SRC]       fifo_req,
  input  logic                 fifo_bit,
  input  logic [1:N_SRC]       src_enable,
  output logic [WORD_BITS-1:0] out_word,
  output logic [4:0]           out_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int CW = $clog2(WORD_BITS + READ_LAT + 1);
  localparam logic [CW-1:0] FIRST_BIT = CW'(READ_LAT);
  localparam logic [CW-1:0] LAST_RD   = CW'(WORD_BITS - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WORD_BITS + READ_LAT - 1);

  state_t         state;
  src_idx_t       grant;
  src_idx_t       last_grant;
  src_idx_t       pick;
  logic           pick_valid;
  logic [CW-1:0]  cyc;
  logic [1:N_SRC] eligible;
  logic           in_window;

  assign eligible = ~fifo_empty & src_enable;

  rr_pick #(
    .N_SRC(N_SRC)
  ) u_rr_pick (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant_valid(pick_valid),
    .grant_idx  (pick)
  );

  // Request line is derived from state so reset drops it at once
  always_comb begin
    fifo_req = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      fifo_req[i] = (state == S_READ) && (grant == src_idx_t'(i));
    end
  end

  assign busy      = (state != S_IDLE);
  assign out_src   = grant;
  assign in_window = ((state == S_READ) || (state == S_WAIT))
                   && (cyc >= FIRST_BIT);

  // Grant, serial capture and output handshake sequencing
  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= src_idx_t'(N_SRC);
      cyc        <= '0;
      out_word   <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (in_window) begin
        out_word <= {out_word[WORD_BITS-2:0], fifo_bit};
      end
      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state      <= S_READ;
            grant      <= pick;
            last_grant <= pick;
            cyc        <= '0;
          end
        end
        S_READ, S_WAIT: begin
          cyc <= cyc + 1'b1;
          if (cyc == LAST_BIT) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
          end else if (cyc == LAST_RD) begin
            state <= S_WAIT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_sched.sv
// Scoreboard bench for fifo_drain_sched.
// Emulates latency-2 serial FIFOs and checks words, order, timing.
module tb_fifo_drain_sched;

  localparam int N = 24;
  localparam int W = 64;
  localparam int L = 2;

  typedef struct packed {
    logic [4:0]  src;
    logic [63:0] word;
  } exp_t;

  logic         fifo_clk   = 1'b0;
  logic         fifo_rst_n = 1'b0;
  logic [1:N]   fifo_empty = '1;
  logic [1:N]   fifo_req;
  logic         fifo_bit   = 1'b0;
  logic [1:N]   src_enable = '1;
  logic [W-1:0] out_word;
  logic [4:0]   out_src;
  logic         out_valid;
  logic         out_ready  = 1'b1;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int bad_onehot = 0;

  exp_t        sb[$];
  exp_t        cur;
  logic [63:0] pat [1:N];

  // driver history: request seen 0, 1 and 2 cycles ago
  logic a0, a1, a2;
  int   s0, s1, s2, k0, k1, k2;

  // run checker state
  int   run_len, mcyc, t0;
  logic prev_v;

  fifo_drain_sched #(
    .N_SRC(N), .WORD_BITS(W), .READ_LAT(L)
  ) dut (
    .fifo_clk  (fifo_clk),
    .fifo_rst_n(fifo_rst_n),
    .fifo_empty(fifo_empty),
    .fifo_req  (fifo_req),
    .fifo_bit  (fifo_bit),
    .src_enable(src_enable),
    .out_word  (out_word),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 fifo_clk = ~fifo_clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge fifo_clk);
    #1;
  endtask

  task automatic expect_word(int s);
    sb.push_back({5'(s), pat[s]});
  endtask

  task automatic wait_words(int n, int budget);
    int   seen;
    int   t;
    logic pv;
    seen = 0;
    t    = 0;
    pv   = out_valid;
    while (seen < n && t < budget) begin
      @(negedge fifo_clk);
      t++;
      if (out_valid && !pv) seen++;
      pv = out_valid;
    end
    if (seen < n) begin
      checks++;
      failures++;
      $display("FAIL timeout_words seen=%0d required=%0d", seen, n);
    end
  endtask

  task automatic wait_req(int budget);
    int t;
    t = 0;
    do begin
      @(negedge fifo_clk);
      t++;
    end while (fifo_req == '0 && t < budget);
    if (fifo_req == '0) begin
      checks++;
      failures++;
      $display("FAIL timeout_req actual=0 required=nonzero");
    end
  endtask

  task automatic wait_idle(int budget);
    int t;
    t = 0;
    do begin
      @(negedge fifo_clk);
      t++;
    end while ((busy || out_valid) && t < budget);
    if (busy || out_valid) begin
      checks++;
      failures++;
      $display("FAIL timeout_idle busy=%0b required=0", busy);
    end
  endtask

  // FIFO model: bit k of a run appears two cycles after its request
  initial begin
    a0 = 0; a1 = 0; a2 = 0;
    s0 = 0; s1 = 0; s2 = 0;
    k0 = 0; k1 = 0; k2 = 0;
    forever begin
      @(negedge fifo_clk);
      if (!fifo_rst_n) begin
        a0 = 0; a1 = 0; a2 = 0;
        fifo_bit = 1'b0;
      end else begin
        a2 = a1; s2 = s1; k2 = k1;
        a1 = a0; s1 = s0; k1 = k0;
        if (fifo_req != '0) begin
          k0 = a0 ? k0 + 1 : 0;
          a0 = 1;
          for (int i = 1; i <= N; i++) begin
            if (fifo_req[i]) s0 = i;
          end
        end else begin
          a0 = 0;
        end
        fifo_bit = (a2 && k2 < W) ? pat[s2][63-k2] : 1'b0;
      end
    end
  end

  // Scoreboard monitor: pop on each accepted word
  initial begin
    forever begin
      @(negedge fifo_clk);
      if (fifo_rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected src=%0d required=none", out_src);
        end else begin
          cur = sb.pop_front();
          check("out_src", 64'(out_src), 64'(cur.src));
          check("out_word", out_word, cur.word);
        end
      end
    end
  end

  // Request run length, one-hot and valid latency checker
  initial begin
    run_len = 0; mcyc = 0; t0 = 0; prev_v = 0;
    forever begin
      @(negedge fifo_clk);
      mcyc++;
      if (!fifo_rst_n) begin
        run_len = 0;
        prev_v  = 0;
      end else begin
        if ($countones(fifo_req) > 1) bad_onehot++;
        if (fifo_req != '0) begin
          if (run_len == 0) t0 = mcyc;
          run_len++;
        end else if (run_len != 0) begin
          check("req_len", 64'(run_len), 64'(W));
          run_len = 0;
        end
        if (out_valid && !prev_v) begin
          check("valid_lat", 64'(mcyc - t0), 64'(W + L));
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    int          bad;
    logic [63:0] hw;
    logic [4:0]  hs;
    logic [1:N]  exp_req;

    for (int i = 1; i <= N; i++) begin
      pat[i] = {32'(i) * 32'h9E3779B9, ~(32'(i) * 32'h85EBCA6B)};
    end
    pat[5] = 64'hDEADBEEF_01234567;

    // reset values
    #12;
    check("rst_req", 64'(fifo_req), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_word", out_word, 64'd0);
    check("rst_src", 64'(out_src), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    step();
    step();
    fifo_rst_n = 1'b1;

    // rotation 3, 7, 24 from reset priority
    fifo_empty[3]  = 1'b0;
    fifo_empty[7]  = 1'b0;
    fifo_empty[24] = 1'b0;
    expect_word(3); expect_word(7); expect_word(24);
    expect_word(3); expect_word(7); expect_word(24);
    wait_words(6, 1000);
    step();
    fifo_empty = '1;
    wait_idle(200);

    // single source, known pattern, re-granted back to back
    fifo_empty[5] = 1'b0;
    expect_word(5);
    expect_word(5);
    wait_words(2, 400);
    step();
    fifo_empty = '1;
    wait_idle(200);

    // consumer stall: hold for 100 cycles, no new request
    out_ready      = 1'b0;
    fifo_empty[11] = 1'b0;
    fifo_empty[12] = 1'b0;
    expect_word(11);
    expect_word(12);
    wait_words(1, 400);
    step();
    fifo_empty[11] = 1'b1;
    hw  = out_word;
    hs  = out_src;
    bad = 0;
    repeat (100) begin
      @(negedge fifo_clk);
      if (out_word !== hw || out_src !== hs || out_valid !== 1'b1
          || fifo_req != '0 || busy !== 1'b1) bad++;
    end
    check("hold_stable", 64'(bad), 64'd0);
    step();
    out_ready = 1'b1;
    wait_words(1, 400);
    step();
    fifo_empty = '1;
    wait_idle(200);

    // empty flag drops mid-read; read still completes
    fifo_empty[2] = 1'b0;
    expect_word(2);
    wait_req(200);
    repeat (10) step();
    fifo_empty[2] = 1'b1;
    wait_words(1, 400);
    wait_idle(200);

    // reset mid-read, then source 1 wins
    fifo_empty[1] = 1'b0;
    fifo_empty[6] = 1'b0;
    wait_req(200);
    exp_req    = '0;
    exp_req[6] = 1'b1;
    check("rr_after_2", 64'(fifo_req), 64'(exp_req));
    repeat (30) @(posedge fifo_clk);
    #2;
    fifo_rst_n = 1'b0;
    #1;
    check("mid_rst_req", 64'(fifo_req), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_word", out_word, 64'd0);
    step();
    step();
    fifo_rst_n = 1'b1;
    expect_word(1);
    wait_req(20);
    exp_req    = '0;
    exp_req[1] = 1'b1;
    check("post_rst_grant", 64'(fifo_req), 64'(exp_req));
    step();
    fifo_empty[1] = 1'b1;
    fifo_empty[6] = 1'b1;
    wait_words(1, 400);
    wait_idle(200);

    // disabled source never granted
    src_enable[9] = 1'b0;
    fifo_empty[9] = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge fifo_clk);
      if (busy || fifo_req != '0) bad++;
    end
    check("disabled_idle", 64'(bad), 64'd0);
    step();
    src_enable[9] = 1'b1;
    expect_word(9);
    wait_words(1, 400);
    step();
    fifo_empty = '1;
    wait_idle(200);

    repeat (5) step();
    check("onehot", 64'(bad_onehot), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_drain_sched.md
FIFO_DRAIN_SCHED -- requirements
Module: fifo_drain_sched

Interface
REQ-001 Parameter N_SRC, default 24: number of block FIFOs served, indexed 1..N_SRC.
REQ-002 Parameter WORD_BITS, default 64: bits per FIFO word, read serially.
REQ-003 Parameter READ_LAT, default 2: cycles from the first fifo_req assertion to the first valid fifo_bit.
REQ-004 Port fifo_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port fifo_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port fifo_empty, input, [1:N_SRC]: per-source FIFO empty flag, synchronous to fifo_clk.
REQ-007 Port fifo_req, output, [1:N_SRC]: per-source read/shift request, one-hot or zero.
REQ-008 Port fifo_bit, input, 1: serial read data, the OR of all sources.
REQ-009 Port src_enable, input, [1:N_SRC]: a 0 bit excludes that source from arbitration.
REQ-010 Port out_word, output, WORD_BITS: assembled word.
REQ-011 Port out_src, output, 5: index (1..N_SRC) of the source that supplied out_word.
REQ-012 Port out_valid, output, 1: out_word/out_src are valid.
REQ-013 Port out_ready, input, 1: consumer accepts the word when it is high together with out_valid.
REQ-014 Port busy, output, 1: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, READ, WAIT, OUT.
- IDLE: pick the next eligible source.
- READ: issue requests to the granted source.
- WAIT: absorb pipeline latency.
- OUT: hold the word until accepted.
REQ-016 A source SHALL be eligible when fifo_empty[i]=0 and src_enable[i]=1.
REQ-017 In IDLE, if any source is eligible, the FSM SHALL grant the first one found searching from last_grant+1 upward, wrapping from N_SRC to 1, and SHALL enter READ on the next cycle.
- last_grant resets to N_SRC, so source 1 has first priority after reset.
REQ-018 In READ, fifo_req[g] SHALL be high for exactly WORD_BITS consecutive cycles, T0..T0+WORD_BITS-1; all other fifo_req bits SHALL be 0.
REQ-019 fifo_bit SHALL be sampled on cycles T0+READ_LAT+k, for k=0..WORD_BITS-1.
- The first sampled bit goes into out_word[WORD_BITS-1] (MSB first).
REQ-020 WAIT SHALL last READ_LAT cycles after READ ends.
- When the last bit is sampled, the FSM SHALL enter OUT, and out_valid SHALL rise on the next cycle.
REQ-021 In OUT, out_word, out_src and out_valid SHALL stay stable until the cycle in which out_ready=1.
- On that cycle the FSM SHALL return to IDLE and clear out_valid.
REQ-022 No new grant SHALL be issued while out_valid=1 (single output buffer).
- Minimum spacing between grants is WORD_BITS+READ_LAT+2 cycles.
REQ-023 Once granted, a read SHALL complete regardless of later changes to fifo_empty or src_enable.
REQ-024 last_grant SHALL update to g at grant time.
REQ-025 A single eligible source that stays non-empty SHALL be re-granted after every completed transfer.
REQ-026 A bit-counter width of clog2(WORD_BITS+READ_LAT+1) SHALL suffice; counters SHALL NOT wrap within a transfer.

Reset
REQ-027 While fifo_rst_n=0, all of the following SHALL hold asynchronously:
- state=IDLE; fifo_req=0; out_valid=0; out_word=0; out_src=0; busy=0; last_grant=N_SRC.
REQ-028 Reset asserted mid-READ SHALL drop fifo_req to 0 immediately, and the partial word SHALL be discarded.
REQ-029 After reset release, the first grant SHALL occur no earlier than the first clock edge on which fifo_rst_n is sampled high.

Structure
REQ-030 A shared package SHALL hold:
- the state enum;
- the N_SRC default;
- the source-index type (5-bit, 1-based);
- a round-robin search function.
REQ-031 The rotating-priority search SHALL be one sub-module, rr_pick (inputs eligible and last_grant; outputs grant_valid and grant_idx). The rest of the block SHALL be flat.

Verification
REQ-032 After reset, only source 5 non-empty and fifo_bit driven as pattern 64'hDEADBEEF_01234567 from T0+2 -> fifo_req[5] high for exactly 64 cycles; out_word=64'hDEADBEEF_01234567; out_src=5.
REQ-033 Sources 3, 7 and 24 continuously non-empty, out_ready tied 1 -> grant order 3, 7, 24, 3, 7, 24.
REQ-034 out_ready held 0 for 100 cycles after out_valid -> outputs stable throughout; no fifo_req asserted; the next grant occurs only after acceptance.
REQ-035 fifo_empty[g] asserted mid-READ -> the read still lasts 64 cycles and completes with out_src=g.
REQ-036 fifo_rst_n pulled low at read bit 30 -> fifo_req=0 and out_valid=0 in the same cycle; after release, the first grant goes to source 1 if it is eligible.
REQ-037 src_enable[9]=0 with source 9 non-empty -> source 9 is never granted; busy stays 0 if no other source is eligible.
